mbox_uart_responder: RTL and testbench

Responder end of the CPU mailbox at 0xFFFD (ACK), 0xFFFE (REQ) and 0xFFFF (DATA).
- The CPU posts a byte in DATA, then writes a new REQ value.
- The block services the request over an 8N1 UART and bumps ACK once the request is done.
- It sits beside the RAM on the Z80 bus and drives the top-level tx/rx pins.

---
 rtl/mbox_uart_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_mbox_uart_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_uart_responder.sv
// mbox_uart_responder: responder end of the CPU mailbox (ACK/REQ/DATA at BASE_ADDR..+2).
// A new REQ value starts a request: transmit DATA as an 8N1 UART frame, then bump ACK.
// Optional receive path (REQ[7]=1) is built when the macro MBOX_RX_EN is defined.
module mbox_uart_responder #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [15:0] BASE_ADDR    = 16'hFFFD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        mreq_n,
   input  logic        rd_n,
   input  logic        wr_n,
   input  logic [7:0]  di,
   output logic [7:0]  dout,
   output logic        sel,
   output logic        tx,
   input  logic        rx,
   output logic        busy
);

   localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [15:0] AddrReq  = BASE_ADDR + 16'd1;
   localparam logic [15:0] AddrData = BASE_ADDR + 16'd2;

   typedef enum logic [3:0] {
      StIdle, StTxStart, StTxBits, StTxStop, StDone,
      StRxWait, StRxStart, StRxBits, StRxStop
   } state_e;

   state_e          state_q, state_d;
   logic [7:0]      ack_q, ack_d;
   logic [7:0]      req_q, req_d;
   logic [7:0]      req_last_q, req_last_d;
   logic [7:0]      data_q, data_d;
   logic [7:0]      sh_q, sh_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            tx_q, tx_d;
   logic            wr_n_q;

   logic hit_ack, hit_req, hit_data, wr_evt, ack_clr, cnt_last;

   assign hit_ack  = (addr == BASE_ADDR);
   assign hit_req  = (addr == AddrReq);
   assign hit_data = (addr == AddrData);
   assign sel      = !mreq_n && (hit_ack || hit_req || hit_data);
   // Write strobe edge: a held wr_n writes exactly once.
   assign wr_evt   = sel && !wr_n && wr_n_q;
   assign ack_clr  = wr_evt && hit_ack;
   assign cnt_last = (cnt_q == CntLast);
   assign tx       = tx_q;
   assign busy     = busy_q;

`ifdef MBOX_RX_EN
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);
   logic rx_s1_q, rx_s2_q, rx_prev_q;

   // rx synchronizer plus one delayed copy for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
      end
   end
`else
   logic unused_rx;
   assign unused_rx = rx;
`endif

   // Combinational read mux; reads have no side effects
   always_comb begin
      dout = 8'h00;
      if (sel && !rd_n) begin
         if (hit_ack)       dout = ack_q;
         else if (hit_req)  dout = req_q;
         else if (hit_data) dout = data_q;
      end
   end

   // Next-state: CPU register writes, request FSM, UART bit timing
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      req_last_d = req_last_q;
      data_d     = data_q;
      sh_d       = sh_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      tx_d       = tx_q;

      if (wr_evt && hit_req)  req_d  = di;
      if (wr_evt && hit_data) data_d = di;
      // Clear and DONE in the same cycle yields 1
      ack_d = (ack_clr ? 8'h00 : ack_q) + {7'd0, state_q == StDone};

      unique case (state_q)
         StIdle: begin
            // REQ writes made while busy coalesce: only the latest value is compared here
            if (req_q != req_last_q) begin
               req_last_d = req_q;
               busy_d     = 1'b1;
               cnt_d      = '0;
               idx_d      = 3'd0;
               if (req_q[7]) begin
`ifdef MBOX_RX_EN
                  state_d = StRxWait;
`else
                  state_d = StDone;
`endif
               end else begin
                  state_d = StTxStart;
                  sh_d    = data_q;
                  tx_d    = 1'b0;
               end
            end
         end
         StTxStart: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = StTxBits;
               tx_d    = sh_q[0];
            end
         end
         StTxBits: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_last) begin
               cnt_d = '0;
               sh_d  = {1'b0, sh_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = StTxStop;
                  tx_d    = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = sh_q[1];
               end
            end
         end
         StTxStop: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_last) begin
               cnt_d   = '0;
               state_d = StDone;
            end
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
`ifdef MBOX_RX_EN
         StRxWait: begin
            if (ack_clr) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end else if (rx_prev_q && !rx_s2_q) begin
               cnt_d   = '0;
               state_d = StRxStart;
            end
         end
         StRxStart: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntHalf && rx_s2_q) begin
               state_d = StRxWait;
            end else if (cnt_last) begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               state_d = StRxBits;
            end
         end
         StRxBits: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntHalf) sh_d = {rx_s2_q, sh_q[7:1]};
            if (cnt_last) begin
               cnt_d = '0;
               if (idx_q == 3'd7) state_d = StRxStop;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         StRxStop: begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntHalf) begin
               cnt_d = '0;
               if (rx_s2_q) begin
                  data_d  = sh_q;  // overrides a same-cycle CPU DATA write
                  state_d = StDone;
               end else begin
                  state_d = StRxWait;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State and register update with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         ack_q      <= 8'h00;
         req_q      <= 8'h00;
         req_last_q <= 8'h00;
         data_q     <= 8'h00;
         sh_q       <= 8'h00;
         cnt_q      <= '0;
         idx_q      <= 3'd0;
         busy_q     <= 1'b0;
         tx_q       <= 1'b1;
         wr_n_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         req_q      <= req_d;
         req_last_q <= req_last_d;
         data_q     <= data_d;
         sh_q       <= sh_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         tx_q       <= tx_d;
         wr_n_q     <= wr_n;
      end
   end

endmodule

// File: tb/tb_mbox_uart_responder.sv
// tb_mbox_uart_responder: scoreboard bench; tx frames and CPU reads are checked by monitors.
// Receive-path cases are built only when MBOX_RX_EN is defined.
module tb_mbox_uart_responder;

   localparam int unsigned Cpb = 4;
   localparam logic [15:0] AddrAck  = 16'hFFFD;
   localparam logic [15:0] AddrReq  = 16'hFFFE;
   localparam logic [15:0] AddrData = 16'hFFFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] addr = 16'h0000;
   logic        mreq_n = 1'b1;
   logic        rd_n = 1'b1;
   logic        wr_n = 1'b1;
   logic [7:0]  di = 8'h00;
   logic [7:0]  dout;
   logic        sel;
   logic        tx;
   logic        rx = 1'b1;
   logic        busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] val;
      logic       sel;
   } rd_exp_t;

   logic [7:0] exp_tx[$];
   rd_exp_t    exp_rd[$];

   mbox_uart_responder #(
      .CLKS_PER_BIT(Cpb),
      .BASE_ADDR   (AddrAck)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .mreq_n(mreq_n),
      .rd_n  (rd_n),
      .wr_n  (wr_n),
      .di    (di),
      .dout  (dout),
      .sel   (sel),
      .tx    (tx),
      .rx    (rx),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      addr = a; di = d; mreq_n = 1'b0; wr_n = 1'b0;
      tick();
      mreq_n = 1'b1; wr_n = 1'b1;
      tick();
   endtask

   task automatic cpu_read(input string name, input logic [15:0] a, input logic [7:0] exp,
                           input logic exp_sel);
      rd_exp_t e;
      e.name = name; e.val = exp; e.sel = exp_sel;
      exp_rd.push_back(e);
      addr = a; mreq_n = 1'b0; rd_n = 1'b0;
      tick();
      mreq_n = 1'b1; rd_n = 1'b1;
   endtask

   // Counts cycles busy stays high; flags a request that never finishes.
   task automatic wait_idle(output int n);
      int t;
      t = 0; n = 0;
      while (busy !== 1'b1 && t < 20) begin tick(); t++; end
      while (busy === 1'b1 && t < 3000) begin n++; tick(); t++; end
      if (busy !== 1'b0) begin
         checks++; errors++;
         $display("FAIL idle timeout: busy got %b expected 0", busy);
      end
   endtask

`ifdef MBOX_RX_EN
   task automatic send_rx(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (Cpb) tick();
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Cpb) tick();
      end
      rx = stop;
      repeat (Cpb + 2) tick();
      rx = 1'b1;
   endtask
`endif

   // Read monitor: compare dout/sel against the queued expectation
   always @(negedge clk) begin
      if (mreq_n === 1'b0 && rd_n === 1'b0) begin
         if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected read: got %0h expected none", dout);
         end else begin
            rd_exp_t e;
            e = exp_rd.pop_front();
            check(e.name, dout, e.val);
            check({e.name, " sel"}, sel, e.sel);
         end
      end
   end

   // Frame monitor: decode 8N1 frames on tx at mid-bit, abandon on reset
   logic       mon_act = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_sh = 8'h00;
   always @(negedge clk) begin
      if (reset) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            mon_act = 1'b1;
            mon_cnt = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt == 2) begin
            if (tx !== 1'b0) begin
               check("start bit", tx, 0);
               mon_act = 1'b0;
            end
         end else if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) begin
            mon_sh = {tx, mon_sh[7:1]};
         end else if (mon_cnt == 38) begin
            mon_act = 1'b0;
            check("stop bit", tx, 1);
            if (exp_tx.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected frame: got %0h expected none", mon_sh);
            end else begin
               check("tx byte", mon_sh, exp_tx.pop_front());
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int n;
      logic seen;

      // Reset state
      repeat (3) tick();
      check("reset tx", tx, 1);
      check("reset busy", busy, 0);
      check("reset sel", sel, 0);
      check("reset dout", dout, 0);
      reset = 1'b0;
      tick();
      cpu_read("reset ack", AddrAck, 8'h00, 1'b1);
      cpu_read("reset req", AddrReq, 8'h00, 1'b1);
      cpu_read("reset data", AddrData, 8'h00, 1'b1);
      cpu_read("outside window", 16'h1234, 8'h00, 1'b0);

      // 1: basic frame 0x55
      cpu_write(AddrData, 8'h55);
      exp_tx.push_back(8'h55);
      cpu_write(AddrReq, 8'h01);
      check("t1 busy at start", busy, 1);
      check("t1 tx start", tx, 0);
      wait_idle(n);
      check("t1 busy cycles", n, 41);
      cpu_read("t1 ack", AddrAck, 8'h01, 1'b1);

      // 2: held write strobe
      exp_tx.push_back(8'h55);
      addr = AddrReq; di = 8'h02; mreq_n = 1'b0; wr_n = 1'b0;
      repeat (6) tick();
      mreq_n = 1'b1; wr_n = 1'b1;
      wait_idle(n);
      cpu_read("t2 ack", AddrAck, 8'h02, 1'b1);

      // 3: coalesced requests during a frame
      cpu_write(AddrData, 8'h3C);
      exp_tx.push_back(8'h3C);
      cpu_write(AddrReq, 8'h10);
      cpu_write(AddrReq, 8'h03);
      cpu_write(AddrReq, 8'h04);
      cpu_write(AddrData, 8'hA5);
      exp_tx.push_back(8'hA5);
      wait_idle(n);
      wait_idle(n);
      cpu_read("t3 ack", AddrAck, 8'h04, 1'b1);
      cpu_read("t3 req", AddrReq, 8'h04, 1'b1);
      cpu_read("t3 data", AddrData, 8'hA5, 1'b1);

      // 4: same REQ value, clear/DONE collision, ACK clear, wrap
      cpu_write(AddrReq, 8'h04);
      seen = 1'b0;
      repeat (20) begin tick(); seen = seen | busy; end
      check("t4 no request", seen, 0);
      cpu_read("t4 ack unchanged", AddrAck, 8'h04, 1'b1);
      cpu_write(AddrData, 8'h77);
      exp_tx.push_back(8'h77);
      cpu_write(AddrReq, 8'h05);
      repeat (40) tick();
      addr = AddrAck; di = 8'h7E; mreq_n = 1'b0; wr_n = 1'b0;
      tick();
      mreq_n = 1'b1; wr_n = 1'b1;
      check("t4 busy after done", busy, 0);
      cpu_read("t4 collision ack", AddrAck, 8'h01, 1'b1);
      cpu_write(AddrAck, 8'h7E);
      cpu_read("t4 ack cleared", AddrAck, 8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         cpu_write(AddrData, 8'(i));
         exp_tx.push_back(8'(i));
         cpu_write(AddrReq, 8'h20 | 8'(i & 1));
         wait_idle(n);
         if (i == 254) cpu_read("t4 ack 255", AddrAck, 8'hFF, 1'b1);
      end
      cpu_read("t4 ack wrap", AddrAck, 8'h00, 1'b1);

      // 5: reset in the middle of data bit 3
      cpu_write(AddrData, 8'h00);
      exp_tx.push_back(8'h00);
      cpu_write(AddrReq, 8'h40);
      wait_idle(n);
      cpu_write(AddrReq, 8'h41);
      repeat (17) tick();
      check("t5 tx bit3", tx, 0);
      reset = 1'b1;
      tick();
      check("t5 tx after reset", tx, 1);
      check("t5 busy after reset", busy, 0);
      reset = 1'b0;
      cpu_read("t5 ack after reset", AddrAck, 8'h00, 1'b1);
      cpu_read("t5 req after reset", AddrReq, 8'h00, 1'b1);
      cpu_write(AddrData, 8'h96);
      exp_tx.push_back(8'h96);
      cpu_write(AddrReq, 8'h01);
      wait_idle(n);
      check("t5 busy cycles", n, 41);
      cpu_read("t5 ack", AddrAck, 8'h01, 1'b1);

`ifdef MBOX_RX_EN
      // 6: receive path
      cpu_write(AddrReq, 8'h80);
      send_rx(8'h3C, 1'b1);
      wait_idle(n);
      cpu_read("t6 rx data", AddrData, 8'h3C, 1'b1);
      cpu_read("t6 rx ack", AddrAck, 8'h02, 1'b1);
      cpu_write(AddrReq, 8'h81);
      rx = 1'b0;
      repeat (2) tick();
      rx = 1'b1;
      repeat (20) tick();
      check("t6 glitch still waiting", busy, 1);
      cpu_read("t6 glitch ack", AddrAck, 8'h02, 1'b1);
      send_rx(8'h5A, 1'b0);
      repeat (20) tick();
      check("t6 framing still waiting", busy, 1);
      cpu_read("t6 framing data", AddrData, 8'h3C, 1'b1);
      cpu_read("t6 framing ack", AddrAck, 8'h02, 1'b1);
      cpu_write(AddrAck, 8'h11);
      repeat (3) tick();
      check("t6 abort busy", busy, 0);
      cpu_read("t6 abort ack", AddrAck, 8'h00, 1'b1);
`else
      // 6: receive request without the receive path completes immediately
      cpu_write(AddrReq, 8'h80);
      check("t6 tx idle", tx, 1);
      wait_idle(n);
      check("t6 busy cycles", n, 1);
      cpu_read("t6 ack", AddrAck, 8'h02, 1'b1);
`endif

      repeat (60) tick();
      check("frames outstanding", exp_tx.size(), 0);
      check("reads outstanding", exp_rd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
